lbm_fixed_divider: RTL and testbench

Iterative signed fixed-point divider that services the LBM controller's `div_start`/`div_valid` handshake. It computes the macroscopic velocity terms ux = (ρ·ux)/ρ and uy = (ρ·uy)/ρ for one lattice node per request. The controller pulses `div_start` with operands stable, stalls on `div_busy`, and loads `quotient` into the UX/UY registers when `div_valid` pulses. One quotient bit is resolved per clock (restoring algorithm).

---
 rtl/lbm_fixed_divider.sv | 116 +++++++++++
 tb/tb_lbm_fixed_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lbm_fixed_divider.sv
// Iterative restoring signed fixed-point divider (one quotient bit per clock) for the LBM velocity terms.
// Optional macro LBM_DIV_SATURATE_EN clamps out-of-range results instead of wrapping.
module lbm_fixed_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         div_start,
  input  logic signed [DATA_WIDTH-1:0] dividend,
  input  logic signed [DATA_WIDTH-1:0] divisor,
  output logic signed [DATA_WIDTH-1:0] quotient,
  output logic                         div_valid,
  output logic                         div_busy,
  output logic                         div_by_zero
);

  localparam int N     = DATA_WIDTH + FRAC_BITS;
  localparam int CNT_W = $clog2(N + 1);

`ifdef LBM_DIV_SATURATE_EN
  localparam logic [N-1:0] SAT_HALF = N'(1) << (DATA_WIDTH - 1);
`endif

  typedef enum logic {IDLE, DIVIDE} state_t;

  state_t                 state;
  logic [N-1:0]           num_q;
  logic [DATA_WIDTH-1:0]  rem_q;
  logic [DATA_WIDTH-1:0]  dvs_q;
  logic                   neg_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [DATA_WIDTH:0]    rem_shift;
  logic [DATA_WIDTH:0]    rem_sub;
  logic                   q_bit;
  logic [N-1:0]           num_next;

  // Unsigned magnitude; the most negative value maps to 2^(W-1), which is representable unsigned.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] u;
    u = v;
    return v[DATA_WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] apply_sign(input logic [N-1:0] raw,
                                                             input logic       neg);
    logic [DATA_WIDTH-1:0] mag;
    mag = raw[DATA_WIDTH-1:0];
`ifdef LBM_DIV_SATURATE_EN
    if (!neg && (raw >= SAT_HALF))
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    if (neg && (raw > SAT_HALF))
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // Borrow out of the trial subtraction decides the quotient bit.
  always_comb begin
    rem_shift = {rem_q, num_q[N-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    q_bit     = ~rem_sub[DATA_WIDTH];
    num_next  = {num_q[N-2:0], q_bit};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      num_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      quotient    <= '0;
      div_valid   <= 1'b0;
      div_busy    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      div_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start) begin
            if (divisor == '0) begin
              quotient    <= '0;
              div_by_zero <= 1'b1;
              div_valid   <= 1'b1;
            end else begin
              neg_q    <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
              dvs_q    <= magnitude(divisor);
              num_q    <= {magnitude(dividend), {FRAC_BITS{1'b0}}};
              rem_q    <= '0;
              cnt_q    <= CNT_W'(N);
              div_busy <= 1'b1;
              state    <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem_q <= q_bit ? rem_sub[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
          num_q <= num_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            quotient    <= apply_sign(num_next, neg_q);
            div_valid   <= 1'b1;
            div_by_zero <= 1'b0;
            div_busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbm_fixed_divider.sv
// Scoreboard bench for lbm_fixed_divider: directed vectors push expectations, a negedge monitor checks each div_valid.
module tb_lbm_fixed_divider;

  localparam int N = 48;

`ifdef LBM_DIV_SATURATE_EN
  localparam logic [31:0] OVF_Q = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OVF_Q = 32'h0000_0000;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        div_start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient;
  logic        div_valid;
  logic        div_busy;
  logic        div_by_zero;

  lbm_fixed_divider #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
    .Clk(Clk), .Reset(Reset), .div_start(div_start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .div_valid(div_valid), .div_busy(div_busy), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] q;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation, on its due cycle.
  always @(negedge Clk) begin
    if (!Reset && div_valid) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid actual=q %h required=no valid", quotient);
      end else begin
        cur = sbq.pop_front();
        check("quotient", quotient, cur.q);
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, cur.dbz});
        check("valid_cycle", 32'(cyc), 32'(cur.due));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    exp_t e;
    @(negedge Clk);
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
    e.q   = q;
    e.dbz = (b == 32'h0);
    e.due = cyc + 1 + ((b == 32'h0) ? 0 : N);
    sbq.push_back(e);
  endtask

  task automatic wait_done(output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      div_start = 1'b0;
      #1;
      if (div_busy) busy_cnt++;
      if (sbq.size() == 0) return;
    end
    tests++;
    fails++;
    $display("FAIL timeout actual=%0d pending required=0 pending", sbq.size());
    sbq.delete();
  endtask

  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input int exp_busy);
    int bc;
    issue(a, b, q);
    wait_done(bc);
    check({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
  endtask

  initial begin
    int bc;
    int nv;
    exp_t e;
    #1;
    check("reset_quotient", quotient, 32'h0);
    check("reset_valid", {31'b0, div_valid}, 32'h0);
    check("reset_busy", {31'b0, div_busy}, 32'h0);
    check("reset_dbz", {31'b0, div_by_zero}, 32'h0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    run_vec("pos_3_div_2",   32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 48);
    run_vec("neg_3_div_2",   32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 48);
    run_vec("min_div_1",     32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 48);
    run_vec("div_by_zero",   32'h0005_0000, 32'h0000_0000, 32'h0000_0000, 0);
    run_vec("overflow",      32'h7FFF_0000, 32'h0000_0001, OVF_Q,         48);
    run_vec("zero_dividend", 32'h0000_0000, 32'h0002_0000, 32'h0000_0000, 48);
    run_vec("one_third",     32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 48);
    run_vec("neg_one_third", 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 48);
    run_vec("pos_div_neg",   32'h0003_0000, 32'hFFFE_0000, 32'hFFFE_8000, 48);
    run_vec("neg_div_neg",   32'hFFFD_0000, 32'hFFFE_0000, 32'h0001_8000, 48);

    // A start with new operands during DIVIDE must not disturb the running request.
    issue(32'h0001_0000, 32'h0003_0000, 32'h0000_5555);
    repeat (10) begin
      @(negedge Clk);
      div_start = 1'b0;
    end
    dividend  = 32'h7FFF_0000;
    divisor   = 32'h0000_0000;
    div_start = 1'b1;
    wait_done(bc);

    // Back-to-back: second request issued in the valid cycle of the first.
    issue(32'h0003_0000, 32'h0002_0000, 32'h0001_8000);
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      div_start = 1'b0;
      if (div_valid) begin
        nv = 1;
        break;
      end
    end
    check("b2b_first_seen", 32'(nv), 32'd1);
    dividend  = 32'hFFFD_0000;
    divisor   = 32'h0002_0000;
    div_start = 1'b1;
    e.q   = 32'hFFFE_8000;
    e.dbz = 1'b0;
    e.due = cyc + 1 + N;
    sbq.push_back(e);
    wait_done(bc);

    // Asynchronous reset between edges aborts a running request.
    issue(32'h0003_0000, 32'h0002_0000, 32'h0001_8000);
    repeat (20) begin
      @(negedge Clk);
      div_start = 1'b0;
    end
    check("busy_before_reset", {31'b0, div_busy}, 32'h1);
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check("abort_quotient", quotient, 32'h0);
    check("abort_valid", {31'b0, div_valid}, 32'h0);
    check("abort_busy", {31'b0, div_busy}, 32'h0);
    check("abort_dbz", {31'b0, div_by_zero}, 32'h0);
    sbq.delete();
    @(negedge Clk);
    Reset = 1'b0;
    nv = 0;
    repeat (70) begin
      @(negedge Clk);
      if (div_valid) nv++;
    end
    check("abort_no_valid", 32'(nv), 32'd0);

    run_vec("after_reset", 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 48);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
